mat_cache_ctrl: RTL and testbench

Sequencer in front of the matrix cache (dual-block diagonal/row/column store of `shortreal` tiles). Accepts one command at a time over a valid/ready handshake and turns it into a cycle-by-cycle stream of cache control signals:
- diagonal loads from an input beat stream;
- diagonal read sweeps toward the systolic array under consumer backpressure;
- single-cycle in-place transposes.

---
 rtl/mat_cache_ctrl.sv | 151 +++++++++++++++
 tb/tb_mat_cache_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_cache_ctrl.sv
// Command sequencer for the matrix cache: turns LOAD / STREAM / TRANSPOSE
// commands into per-cycle cache read, write and transpose controls.
module mat_cache_ctrl #(
  parameter int WIDTH           = 128,
  parameter int WIDTH_ADDR_SIZE = 1 + $clog2(WIDTH),
  parameter int CACHE_SIZE      = 4,
  parameter int CACHE_ADDR_SIZE = $clog2(CACHE_SIZE)
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr1,
  input  logic [CACHE_ADDR_SIZE-1:0] cmd_addr2,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       cache_read_enable,
  output logic                       cache_write_enable,
  output logic                       cache_transpose_enable,
  output logic [1:0]                 cache_read_type,
  output logic [1:0]                 cache_write_type,
  output logic [CACHE_ADDR_SIZE-1:0] cache_read_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] cache_read_addr2,
  output logic [CACHE_ADDR_SIZE-1:0] cache_write_addr1,
  output logic [CACHE_ADDR_SIZE-1:0] cache_write_addr2,
  output logic [WIDTH_ADDR_SIZE-1:0] cache_read_param,
  output logic [WIDTH_ADDR_SIZE-1:0] cache_write_param
);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, XPOSE} state_e;

  localparam logic [1:0] OP_LOAD   = 2'd0;
  localparam logic [1:0] OP_STREAM = 2'd1;
  localparam logic [1:0] OP_XPOSE  = 2'd2;
  localparam logic [WIDTH_ADDR_SIZE-1:0] LAST_BEAT = WIDTH_ADDR_SIZE'(WIDTH - 1);

  state_e                     state_q, state_d;
  logic [WIDTH_ADDR_SIZE-1:0] cnt_q, cnt_d;
  logic [CACHE_ADDR_SIZE-1:0] addr1_q, addr1_d;
  logic [CACHE_ADDR_SIZE-1:0] addr2_q, addr2_d;
  logic                       done_q, done_d;
  logic                       ready_q, ready_d;
  logic                       accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr1_q <= '0;
      addr2_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign accept = cmd_valid && ready_q && (state_q == IDLE);

  // The counter parks at the last beat on completion instead of wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          addr1_d = cmd_addr1;
          addr2_d = cmd_addr2;
          cnt_d   = '0;
          case (cmd_op)
            OP_LOAD:   state_d = LOAD;
            OP_STREAM: state_d = STREAM;
            OP_XPOSE:  state_d = XPOSE;
            default:   done_d  = 1'b1;
          endcase
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      XPOSE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
  end

  always_comb begin
    in_ready               = 1'b0;
    out_valid              = 1'b0;
    cache_read_enable      = 1'b0;
    cache_write_enable     = 1'b0;
    cache_transpose_enable = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready           = 1'b1;
        cache_write_enable = in_valid;
      end
      STREAM: begin
        out_valid         = 1'b1;
        cache_read_enable = 1'b1;
      end
      XPOSE:   cache_transpose_enable = 1'b1;
      default: ;
    endcase
    cmd_ready         = ready_q;
    done              = done_q;
    busy              = (state_q != IDLE);
    cache_read_type   = 2'd0;
    cache_write_type  = 2'd0;
    cache_read_addr1  = addr1_q;
    cache_read_addr2  = addr2_q;
    cache_write_addr1 = addr1_q;
    cache_write_addr2 = addr2_q;
    cache_read_param  = cnt_q;
    cache_write_param = cnt_q;
  end

endmodule

// File: tb/tb_mat_cache_ctrl.sv
// Self-checking bench for mat_cache_ctrl: directed vector table, hand-written
// back-to-back and mid-command reset sequences, then randomized traffic.
module tb_mat_cache_ctrl;

  localparam int WIDTH = 4;
  localparam int WAS   = 1 + $clog2(WIDTH);
  localparam int CS    = 4;
  localparam int CAS   = $clog2(CS);

  logic           clock;
  logic           reset_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_op;
  logic [CAS-1:0] cmd_addr1;
  logic [CAS-1:0] cmd_addr2;
  logic           in_valid;
  logic           in_ready;
  logic           out_valid;
  logic           out_ready;
  logic           busy;
  logic           done;
  logic           cache_read_enable;
  logic           cache_write_enable;
  logic           cache_transpose_enable;
  logic [1:0]     cache_read_type;
  logic [1:0]     cache_write_type;
  logic [CAS-1:0] cache_read_addr1;
  logic [CAS-1:0] cache_read_addr2;
  logic [CAS-1:0] cache_write_addr1;
  logic [CAS-1:0] cache_write_addr2;
  logic [WAS-1:0] cache_read_param;
  logic [WAS-1:0] cache_write_param;

  mat_cache_ctrl #(
    .WIDTH(WIDTH), .WIDTH_ADDR_SIZE(WAS), .CACHE_SIZE(CS), .CACHE_ADDR_SIZE(CAS)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr1(cmd_addr1), .cmd_addr2(cmd_addr2),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done),
    .cache_read_enable(cache_read_enable),
    .cache_write_enable(cache_write_enable),
    .cache_transpose_enable(cache_transpose_enable),
    .cache_read_type(cache_read_type), .cache_write_type(cache_write_type),
    .cache_read_addr1(cache_read_addr1), .cache_read_addr2(cache_read_addr2),
    .cache_write_addr1(cache_write_addr1), .cache_write_addr2(cache_write_addr2),
    .cache_read_param(cache_read_param), .cache_write_param(cache_write_param)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: is a command running, which one, how many
  // beats it has moved, and whether a completion is being reported.
  bit           mActive;
  int           mOp;
  int           mBeats;
  bit           mDone;
  bit           mReady;
  logic [CAS-1:0] mA1, mA2;

  typedef struct {
    bit       cv;
    bit [1:0] op;
    bit [1:0] a1;
    bit [1:0] a2;
    bit       iv;
    bit       ordy;
    bit       we;
    bit       re;
    bit       xp;
    int       param;
    bit       dn;
    bit       rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit cv, bit [1:0] op, bit [1:0] a1, bit [1:0] a2,
                              bit iv, bit ordy, bit we, bit re, bit xp,
                              int param, bit dn, bit rdy);
    vec_t v;
    v.cv = cv; v.op = op; v.a1 = a1; v.a2 = a2; v.iv = iv; v.ordy = ordy;
    v.we = we; v.re = re; v.xp = xp; v.param = param; v.dn = dn; v.rdy = rdy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mActive = 1'b0; mOp = 0; mBeats = 0; mDone = 1'b0; mReady = 1'b0;
    mA1 = '0; mA2 = '0;
  endtask

  task automatic finishCmd();
    mActive = 1'b0; mDone = 1'b1; mReady = 1'b1;
  endtask

  // Advance the reference by one rising edge using the inputs held at that edge.
  task automatic modelStep();
    mDone = 1'b0;
    if (!mActive) begin
      if (mReady && cmd_valid) begin
        mA1 = cmd_addr1; mA2 = cmd_addr2;
        if (cmd_op == 2'd3) begin
          mDone = 1'b1;
        end else begin
          mActive = 1'b1; mOp = int'(cmd_op); mBeats = 0; mReady = 1'b0;
        end
      end else begin
        mReady = 1'b1;
      end
    end else if (mOp == 0) begin
      if (in_valid) begin
        mBeats++;
        if (mBeats == WIDTH) finishCmd();
      end
    end else if (mOp == 1) begin
      if (out_ready) begin
        mBeats++;
        if (mBeats == WIDTH) finishCmd();
      end
    end else begin
      finishCmd();
    end
  endtask

  task automatic checkAll();
    bit isLoad, isStream, isXpose;
    isLoad   = mActive && (mOp == 0);
    isStream = mActive && (mOp == 1);
    isXpose  = mActive && (mOp == 2);
    checkOutput("cmd_ready", cmd_ready, mReady);
    checkOutput("done", done, mDone);
    checkOutput("busy", busy, mActive);
    checkOutput("in_ready", in_ready, isLoad);
    checkOutput("write_enable", cache_write_enable, isLoad && in_valid);
    checkOutput("read_enable", cache_read_enable, isStream);
    checkOutput("out_valid", out_valid, isStream);
    checkOutput("transpose_enable", cache_transpose_enable, isXpose);
    checkOutput("read_type", cache_read_type, 0);
    checkOutput("write_type", cache_write_type, 0);
    if (isLoad)   checkOutput("write_param", cache_write_param, mBeats);
    if (isStream) checkOutput("read_param", cache_read_param, mBeats);
    if (mActive) begin
      checkOutput("write_addr1", cache_write_addr1, mA1);
      checkOutput("write_addr2", cache_write_addr2, mA2);
      checkOutput("read_addr1", cache_read_addr1, mA1);
      checkOutput("read_addr2", cache_read_addr2, mA2);
    end
  endtask

  // Phase convention: tasks start and end 1 time unit after a rising edge.
  task automatic settle();
    #3;
    checkAll();
  endtask

  task automatic advance();
    @(posedge clock);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus();
    settle();
    advance();
  endtask

  task automatic setInputs(input bit cv, input bit [1:0] op, input bit [1:0] a1,
                           input bit [1:0] a2, input bit iv, input bit ordy);
    cmd_valid = cv; cmd_op = op; cmd_addr1 = a1; cmd_addr2 = a2;
    in_valid = iv; out_ready = ordy;
  endtask

  initial begin
    reset_n = 1'b0;
    setInputs(0, 0, 0, 0, 0, 0);
    modelReset();

    #2;
    checkOutput("rst_cmd_ready", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_write_enable", cache_write_enable, 0);
    checkOutput("rst_read_enable", cache_read_enable, 0);
    checkOutput("rst_transpose_enable", cache_transpose_enable, 0);
    checkOutput("rst_write_param", cache_write_param, 0);
    checkOutput("rst_read_param", cache_read_param, 0);
    checkOutput("rst_write_addr1", cache_write_addr1, 0);
    checkOutput("rst_read_addr2", cache_read_addr2, 0);

    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_release_ready_low", cmd_ready, 0);
    advance();

    // Directed vectors: inputs for one cycle and the outputs expected in it.
    vecs.push_back(mk(1,0,2,3, 1,0, 0,0,0,-1, 0,1));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 2, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 1,1));
    vecs.push_back(mk(1,0,1,1, 0,0, 0,0,0,-1, 0,1));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 2, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 0,0));
    vecs.push_back(mk(0,0,0,0, 1,0, 1,0,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 1,1));
    vecs.push_back(mk(1,1,1,0, 0,0, 0,0,0,-1, 0,1));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,1,0, 0, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,1,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,1,0, 1, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,1,0, 2, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,1, 0,1,0, 3, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 1,1));
    vecs.push_back(mk(1,2,2,1, 0,0, 0,0,0,-1, 0,1));
    vecs.push_back(mk(0,0,0,0, 1,0, 0,0,1,-1, 0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 1,1));
    vecs.push_back(mk(1,3,0,0, 1,1, 0,0,0,-1, 0,1));
    vecs.push_back(mk(0,0,0,0, 1,1, 0,0,0,-1, 1,1));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0,0,-1, 0,1));

    for (int i = 0; i < vecs.size(); i++) begin
      setInputs(vecs[i].cv, vecs[i].op, vecs[i].a1, vecs[i].a2, vecs[i].iv, vecs[i].ordy);
      settle();
      checkOutput($sformatf("vec%0d_write_enable", i), cache_write_enable, vecs[i].we);
      checkOutput($sformatf("vec%0d_read_enable", i), cache_read_enable, vecs[i].re);
      checkOutput($sformatf("vec%0d_transpose_enable", i), cache_transpose_enable, vecs[i].xp);
      checkOutput($sformatf("vec%0d_done", i), done, vecs[i].dn);
      checkOutput($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].rdy);
      if (vecs[i].param >= 0 && vecs[i].we)
        checkOutput($sformatf("vec%0d_write_param", i), cache_write_param, vecs[i].param);
      if (vecs[i].param >= 0 && vecs[i].re)
        checkOutput($sformatf("vec%0d_read_param", i), cache_read_param, vecs[i].param);
      if (vecs[i].xp)
        checkOutput($sformatf("vec%0d_xpose_addr1", i), cache_write_addr1, 2);
      advance();
    end

    // Back-to-back: STREAM then LOAD with cmd_valid held high throughout.
    setInputs(1, 1, 3, 2, 0, 1);
    applyStimulus();
    cmd_op = 2'd0;
    repeat (WIDTH) applyStimulus();
    settle();
    checkOutput("b2b_done", done, 1);
    checkOutput("b2b_ready", cmd_ready, 1);
    advance();
    cmd_valid = 1'b0;
    in_valid  = 1'b1;
    settle();
    checkOutput("b2b_no_bubble_busy", busy, 1);
    checkOutput("b2b_no_bubble_in_ready", in_ready, 1);
    checkOutput("b2b_load_param0", cache_write_param, 0);
    advance();
    repeat (WIDTH) applyStimulus();

    // Reset asserted during the second STREAM beat.
    setInputs(1, 1, 2, 1, 0, 1);
    applyStimulus();
    cmd_valid = 1'b0;
    applyStimulus();
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_read_enable", cache_read_enable, 0);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_done", done, 0);
    checkOutput("midrst_cmd_ready", cmd_ready, 0);
    modelReset();
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkAll();
    advance();
    setInputs(1, 0, 0, 3, 1, 0);
    settle();
    checkOutput("midrst_ready_after_release", cmd_ready, 1);
    checkOutput("midrst_no_done", done, 0);
    advance();
    cmd_valid = 1'b0;
    settle();
    checkOutput("midrst_load_param0", cache_write_param, 0);
    checkOutput("midrst_load_write_enable", cache_write_enable, 1);
    advance();
    repeat (WIDTH) applyStimulus();

    // Randomized traffic against the reference.
    for (int n = 0; n < 1500; n++) begin
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr1 = CAS'($urandom_range(0, CS - 1));
      cmd_addr2 = CAS'($urandom_range(0, CS - 1));
      in_valid  = ($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      applyStimulus();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
